// File: rtl/stage_sequencer_pkg.sv
// Shared stage codes and defaults for the multicycle core sequencer.
package stage_sequencer_pkg;

  localparam int unsigned STAGE_W = 3;
  localparam int unsigned WAIT_W  = 4;
  localparam int unsigned CNT_W   = 32;
  localparam logic [31:0] UART_ADDR_DEFAULT = 32'hF6FF_F070;

  typedef enum logic [STAGE_W-1:0] {
    IF_STAGE   = 3'd0,
    RR_STAGE   = 3'd1,
    EX_STAGE   = 3'd2,
    MA_STAGE   = 3'd3,
    RW_STAGE   = 3'd4,
    WU_STAGE   = 3'd5,
    HALT_STAGE = 3'd6
  } stage_e;

endpackage

// File: rtl/stage_sequencer.sv
// Multicycle IF/RR/EX/MA/RW control FSM with UART/load stalls, halt state
// and retired-instruction counter; all outputs are registered.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter logic [31:0] UART_ADDR = UART_ADDR_DEFAULT,
  parameter int unsigned LOAD_WAIT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               is_load,
  input  logic               is_store,
  input  logic               is_halt,
  input  logic               dec_reg_we,
  input  logic [31:0]        mem_address,
  input  logic               uart_busy,
  output logic [STAGE_W-1:0] stage,
  output logic               decoder_rst,
  output logic               alu_rst,
  output logic               ram_we,
  output logic               reg_we,
  output logic               pc_we,
  output logic               uart_we,
  output logic               halted,
  output logic [CNT_W-1:0]   instret
);

  stage_e              state_q;
  stage_e              state_d;
  logic [WAIT_W-1:0]   wait_q;
  logic                is_uart_store;
  logic                first_ma;

  assign stage = state_q;

  // Next-state decode; UART stall only applies to stores hitting the UART address.
  always_comb begin
    state_d       = state_q;
    is_uart_store = is_store && (mem_address == UART_ADDR);
    case (state_q)
      IF_STAGE:   state_d = RR_STAGE;
      RR_STAGE:   state_d = EX_STAGE;
      EX_STAGE:   state_d = (is_uart_store && uart_busy) ? WU_STAGE : MA_STAGE;
      WU_STAGE:   state_d = uart_busy ? WU_STAGE : MA_STAGE;
      MA_STAGE:   state_d = (wait_q == '0) ? RW_STAGE : MA_STAGE;
      RW_STAGE:   state_d = is_halt ? HALT_STAGE : IF_STAGE;
      HALT_STAGE: state_d = HALT_STAGE;
      default:    state_d = IF_STAGE;
    endcase
    first_ma = (state_d == MA_STAGE) && (state_q != MA_STAGE);
  end

  // Strobes are registered from the next state so they line up with their stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IF_STAGE;
      wait_q      <= '0;
      decoder_rst <= 1'b0;
      alu_rst     <= 1'b0;
      ram_we      <= 1'b0;
      reg_we      <= 1'b0;
      pc_we       <= 1'b0;
      uart_we     <= 1'b0;
      halted      <= 1'b0;
      instret     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == EX_STAGE) begin
        wait_q <= is_load ? WAIT_W'(LOAD_WAIT) : '0;
      end else if (state_q == MA_STAGE && wait_q != '0) begin
        wait_q <= wait_q - WAIT_W'(1);
      end
      decoder_rst <= (state_d == RR_STAGE);
      alu_rst     <= (state_d == EX_STAGE);
      ram_we      <= first_ma && is_store && !is_uart_store;
      uart_we     <= first_ma && is_uart_store && !uart_busy;
      reg_we      <= (state_d == RW_STAGE) && dec_reg_we;
      pc_we       <= (state_d == RW_STAGE) && !is_halt;
      halted      <= (state_d == HALT_STAGE);
      if (state_q == RW_STAGE) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer (LOAD_WAIT = 3).
module tb_stage_sequencer;

  localparam logic [31:0] UART = 32'hF6FF_F070;

  logic        clk;
  logic        rst;
  logic        is_load;
  logic        is_store;
  logic        is_halt;
  logic        dec_reg_we;
  logic [31:0] mem_address;
  logic        uart_busy;
  logic [2:0]  stage;
  logic        decoder_rst;
  logic        alu_rst;
  logic        ram_we;
  logic        reg_we;
  logic        pc_we;
  logic        uart_we;
  logic        halted;
  logic [31:0] instret;

  int checks;
  int failures;
  logic [31:0] exp_instret;

  stage_sequencer #(
    .UART_ADDR (UART),
    .LOAD_WAIT (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .is_load     (is_load),
    .is_store    (is_store),
    .is_halt     (is_halt),
    .dec_reg_we  (dec_reg_we),
    .mem_address (mem_address),
    .uart_busy   (uart_busy),
    .stage       (stage),
    .decoder_rst (decoder_rst),
    .alu_rst     (alu_rst),
    .ram_we      (ram_we),
    .reg_we      (reg_we),
    .pc_we       (pc_we),
    .uart_we     (uart_we),
    .halted      (halted),
    .instret     (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_stage"}, 32'(stage), 32'd0);
    check_eq({tag, "_strobes"},
             32'({decoder_rst, alu_rst, ram_we, reg_we, pc_we, uart_we, halted}), 32'd0);
    check_eq({tag, "_instret"}, instret, 32'd0);
  endtask

  // Called at the falling edge of an IF cycle; runs until the next IF or HALT.
  task automatic run_instr(input string tag, input logic ld, input logic st,
                           input logic ht, input logic rw, input logic [31:0] addr,
                           input int busy_lo, input int busy_hi,
                           input int e_cyc, input int e_ma, input int e_wu,
                           input int e_ram, input int e_uart, input int e_reg, input int e_pc);
    int n, ma_n, wu_n, ram_n, uart_n, reg_n, pc_n, viol;
    n = 0; ma_n = 0; wu_n = 0; ram_n = 0; uart_n = 0; reg_n = 0; pc_n = 0; viol = 0;
    is_load = ld; is_store = st; is_halt = ht; dec_reg_we = rw; mem_address = addr;
    while (n < 64) begin
      if (n > 0 && (stage == 3'd0 || stage == 3'd6)) break;
      if (n < 3 && stage != 3'(n)) viol++;
      if (stage == 3'd3) ma_n++;
      if (stage == 3'd5) wu_n++;
      ram_n  += int'(ram_we);
      uart_n += int'(uart_we);
      reg_n  += int'(reg_we);
      pc_n   += int'(pc_we);
      if (ram_we && (stage != 3'd3 || uart_we || reg_we)) viol++;
      if (uart_we && (stage != 3'd3 || uart_busy || reg_we)) viol++;
      if ((reg_we || pc_we) && stage != 3'd4) viol++;
      if (decoder_rst != (stage == 3'd1)) viol++;
      if (alu_rst != (stage == 3'd2)) viol++;
      if (halted) viol++;
      uart_busy = (n >= busy_lo) && (n <= busy_hi);
      @(negedge clk);
      n++;
    end
    uart_busy = 1'b0;
    exp_instret = exp_instret + 32'd1;
    check_eq({tag, "_cycles"}, 32'(n), 32'(e_cyc));
    check_eq({tag, "_ma"}, 32'(ma_n), 32'(e_ma));
    check_eq({tag, "_wu"}, 32'(wu_n), 32'(e_wu));
    check_eq({tag, "_ram_we"}, 32'(ram_n), 32'(e_ram));
    check_eq({tag, "_uart_we"}, 32'(uart_n), 32'(e_uart));
    check_eq({tag, "_reg_we"}, 32'(reg_n), 32'(e_reg));
    check_eq({tag, "_pc_we"}, 32'(pc_n), 32'(e_pc));
    check_eq({tag, "_viol"}, 32'(viol), 32'd0);
    check_eq({tag, "_instret"}, instret, exp_instret);
  endtask

  initial begin
    int bad;
    checks = 0; failures = 0; exp_instret = 32'd0;
    rst = 1'b1; is_load = 1'b0; is_store = 1'b0; is_halt = 1'b0;
    dec_reg_we = 1'b0; mem_address = 32'd0; uart_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset("por");

    //                    ld   st   ht   rw   addr          blo bhi cyc ma wu ram uart reg pc
    run_instr("alu",     1'b0,1'b0,1'b0,1'b1,32'h0,         99, 0,  5,  1, 0, 0,  0,   1,  1);
    run_instr("st_ram",  1'b0,1'b1,1'b0,1'b0,32'h0000_1000, 99, 0,  5,  1, 0, 1,  0,   0,  1);
    run_instr("st_uwait",1'b0,1'b1,1'b0,1'b0,UART,          2,  8,  12, 1, 7, 0,  1,   0,  1);
    run_instr("st_uart", 1'b0,1'b1,1'b0,1'b0,UART,          99, 0,  5,  1, 0, 0,  1,   0,  1);
    run_instr("st_ulate",1'b0,1'b1,1'b0,1'b0,UART,          3,  4,  5,  1, 0, 0,  1,   0,  1);
    run_instr("ld",      1'b1,1'b0,1'b0,1'b1,32'h0000_2000, 99, 0,  8,  4, 0, 0,  0,   1,  1);
    run_instr("ld_uart", 1'b1,1'b0,1'b0,1'b1,UART,          0,  20, 8,  4, 0, 0,  0,   1,  1);

    // Reset while stalled in WU discards the store.
    is_load = 1'b0; is_store = 1'b1; is_halt = 1'b0; dec_reg_we = 1'b0; mem_address = UART;
    uart_busy = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("wu_entered", 32'(stage), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; uart_busy = 1'b0;
    exp_instret = 32'd0;
    check_reset("rst_wu");
    run_instr("alu2",    1'b0,1'b0,1'b0,1'b1,32'h0,         99, 0,  5,  1, 0, 0,  0,   1,  1);

    run_instr("halt",    1'b0,1'b0,1'b1,1'b0,32'h0,         99, 0,  5,  1, 0, 0,  0,   0,  0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (stage != 3'd6 || !halted || instret != exp_instret ||
          decoder_rst || alu_rst || ram_we || reg_we || pc_we || uart_we) bad++;
      @(negedge clk);
    end
    check_eq("halt_hold", 32'(bad), 32'd0);
    check_eq("halt_instret", instret, 32'd2);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_instret = 32'd0;
    check_reset("rst_halt");
    run_instr("alu3",    1'b0,1'b0,1'b0,1'b1,32'h0,         99, 0,  5,  1, 0, 0,  0,   1,  1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
